// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_t   : arbiter sequencing states
//   SZ_*          : RISC-V funct3 access-size encodings
//   MEM_TYPE_WORD : memory-side access type (always full word)
//   is_misaligned : alignment rule used when DMEM_ARB_MISALIGN_EN is defined
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [2:0] MEM_TYPE_WORD = 3'b010;

  // Halfwords need an even address, words a multiple of four.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] offset);
    logic half_bad;
    logic word_bad;
    half_bad = ((size == SZ_H) || (size == SZ_HU)) && offset[0];
    word_bad = (size == SZ_W) && (offset != 2'b00);
    return half_bad | word_bad;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic between full-word memory data and sub-word accesses.
//   ld_word  in  32 : word read from memory
//   st_word  in  32 : buffered word to be merged for a sub-word store
//   wdata    in  32 : right-aligned store data
//   offset   in  2  : byte offset within the word (addr[1:0])
//   size     in  3  : funct3 access size
//   ld_data  out 32 : extracted and sign/zero-extended load result
//   st_data  out 32 : st_word with the addressed lane replaced (wdata for W)
module dmem_lane_unit
  import dmem_arb_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [31:0] st_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = ld_word[{offset, 3'b000} +: 8];
    // Halfword lane is chosen by offset[1] alone, so an odd halfword address
    // (only reachable with alignment checking disabled) reads the enclosing lane.
    half_sel = offset[1] ? ld_word[31:16] : ld_word[15:0];

    case (size)
      SZ_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   ld_data = {24'd0, byte_sel};
      SZ_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   ld_data = {16'd0, half_sel};
      default: ld_data = ld_word;
    endcase

    st_data = st_word;
    case (size)
      SZ_B, SZ_BU: st_data[{offset, 3'b000} +: 8] = wdata[7:0];
      SZ_H, SZ_HU: begin
        if (offset[1]) st_data[31:16] = wdata[15:0];
        else           st_data[15:0]  = wdata[15:0];
      end
      default:     st_data = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between two data-memory requesters and a single-port,
// word-wide memory. Sub-word stores are read-modify-write; sub-word loads are
// lane-extracted and extended here.
//
// Optional feature macro: DMEM_ARB_MISALIGN_EN
//   defined   : misaligned H/HU/W requests complete immediately with err=1
//   undefined : low address bits ignored for H/W, err tied to 0
//
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   pN_req/we/size/addr/wdata  : request from port N (held until pN_gnt)
//   pN_gnt                     : one-cycle grant, request fields sampled here
//   pN_rvalid/rdata/err        : one-cycle completion with load data / error
//   mem_read/write/addr/wdata  : memory-side controls (word accesses only)
//   mem_data_type              : constant word type
//   mem_rdata                  : combinational memory read data
//   busy                       : arbiter is not in IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; grant is combinational from req
// READ  | memory read, word captured (load or sub-word store)
// WRITE | memory write of full word or merged word
// RESP  | rvalid pulse to the owning port
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [2:0]        p0_size,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [2:0]        p1_size,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_data_type,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  logic              last_gnt_q;
  logic              port_q;
  logic              we_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;
  logic [1:0]        rvalid_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              gnt_port;
  logic              grant;
  logic              sel_we;
  logic [2:0]        sel_size_raw;
  logic [2:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              misalign;
  logic              resp_port;
  logic              err_d;
  logic [31:0]       rdata_d;
  logic [31:0]       addr_word;
  logic [31:0]       ld_data;
  logic [31:0]       st_data;

  assign addr_word = 32'(addr_q);

  dmem_lane_unit u_lane (
    .ld_word (mem_rdata),
    .st_word (buf_q),
    .wdata   (wdata_q),
    .offset  (addr_q[1:0]),
    .size    (size_q),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  always_comb begin
    // On a tie the port that was not granted last wins.
    gnt_port     = (p0_req & p1_req) ? ~last_gnt_q : p1_req;
    grant        = (state_q == IDLE) && (p0_req | p1_req) && !rst;
    sel_we       = gnt_port ? p1_we    : p0_we;
    sel_size_raw = gnt_port ? p1_size  : p0_size;
    sel_addr     = gnt_port ? p1_addr  : p0_addr;
    sel_wdata    = gnt_port ? p1_wdata : p0_wdata;
    // Stores have no unsigned variants: BU/HU fold onto B/H.
    sel_size     = {sel_size_raw[2] & ~sel_we, sel_size_raw[1:0]};
`ifdef DMEM_ARB_MISALIGN_EN
    misalign     = is_misaligned(sel_size, sel_addr[1:0]);
`else
    misalign     = 1'b0;
`endif

    state_d   = state_q;
    resp_port = port_q;
    err_d     = 1'b0;
    rdata_d   = 32'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;

    case (state_q)
      IDLE: begin
        resp_port = gnt_port;
        if (grant) begin
          if (misalign) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if (sel_we && (sel_size == SZ_W)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        mem_read = !rst;
        mem_addr = addr_word & ~32'd3;
        if (we_q) begin
          state_d = WRITE;
        end else begin
          state_d = RESP;
          rdata_d = ld_data;
        end
      end
      WRITE: begin
        mem_write = !rst;
        mem_addr  = addr_word & ~32'd3;
        mem_wdata = st_data;
        state_d   = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      buf_q      <= 32'd0;
      rvalid_q   <= 2'b00;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_gnt_q <= gnt_port;
        port_q     <= gnt_port;
        we_q       <= sel_we;
        size_q     <= sel_size;
        addr_q     <= sel_addr;
        wdata_q    <= sel_wdata;
      end
      if (state_q == READ) begin
        buf_q <= mem_rdata;
      end
      if (state_d == RESP) begin
        rvalid_q <= resp_port ? 2'b10 : 2'b01;
        rdata_q  <= rdata_d;
        err_q    <= err_d;
      end else begin
        rvalid_q <= 2'b00;
        rdata_q  <= 32'd0;
        err_q    <= 1'b0;
      end
    end
  end

  assign p0_gnt        = grant & ~gnt_port;
  assign p1_gnt        = grant & gnt_port;
  assign p0_rvalid     = rvalid_q[0];
  assign p1_rvalid     = rvalid_q[1];
  assign p0_rdata      = rvalid_q[0] ? rdata_q : 32'd0;
  assign p1_rdata      = rvalid_q[1] ? rdata_q : 32'd0;
  assign p0_err        = rvalid_q[0] & err_q;
  assign p1_err        = rvalid_q[1] & err_q;
  assign mem_data_type = MEM_TYPE_WORD;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [2:0]  p0_size, p1_size;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_read, mem_write, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_data_type;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_type(mem_data_type), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- memory: 16 words at 0x80000000 ----------------
  function automatic logic [31:0] init_word(input int i);
    case (i)
      2:       return 32'h0000_0088;
      4:       return 32'h1234_F5AA;
      8:       return 32'h1122_3344;
      default: return 32'(32'h9E37_79B9 * (i + 1));
    endcase
  endfunction

  logic [31:0] dmem [16];
  bit          mem_init_done = 1'b0;
  assign mem_rdata = dmem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 16; i++) dmem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else if (mem_write) begin
      dmem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  // ---------------- reference model ----------------
  function automatic int ref_width(input logic [2:0] size);
    return 1 << size[1:0];
  endfunction

  function automatic int ref_off(input logic [31:0] addr, input logic [2:0] size);
    int off;
    off = int'(addr[1:0]);
    return off - (off % ref_width(size));
  endfunction

  function automatic logic [31:0] ref_mask(input logic [2:0] size);
    int w;
    w = ref_width(size);
    return (w == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * w)) - 32'd1);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [2:0] size);
    logic [31:0] v, mask;
    int w;
    w    = ref_width(size);
    mask = ref_mask(size);
    v    = (word >> (8 * ref_off(addr, size))) & mask;
    if (size < 3'd4 && w < 4 && v[8 * w - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] word, input logic [31:0] wdata,
                                            input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] mask;
    int sh;
    mask = ref_mask(size);
    sh   = 8 * ref_off(addr, size);
    return (word & ~(mask << sh)) | ((wdata & mask) << sh);
  endfunction

  function automatic bit ref_mis(input logic [31:0] addr, input logic [2:0] size);
`ifdef DMEM_ARB_MISALIGN_EN
    return (int'(addr[1:0]) % ref_width(size)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] ref_mem [16];
  bit          ref_init = 1'b0;
  bit          pend = 1'b0;
  int          age = 0;
  bit          pport, pwe;
  logic [2:0]  psize;
  logic [31:0] paddr, pwdata;
  bit          last_win = 1'b1;

  always @(negedge clk) begin
    int w, lat, rd_age, wr_age, idx;
    bit mis, done, wide_store;
    if (!ref_init) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      ref_init = 1'b1;
    end
    done = 1'b0;
    if (rst) begin
      pend     = 1'b0;
      last_win = 1'b1;
      check_eq("rst_mem_write", mem_write, 0);
      check_eq("rst_mem_read", mem_read, 0);
      check_eq("rst_gnt", p0_gnt | p1_gnt, 0);
    end else begin
      if (pend) age++;
      check_eq("busy", busy, pend && age > 0);
      check_eq("mem_type", mem_data_type, 3'b010);
      if (!p0_rvalid) check_eq("p0_quiet", {p0_err, p0_rdata}, 0);
      if (!p1_rvalid) check_eq("p1_quiet", {p1_err, p1_rdata}, 0);
      if (pend) begin
        w          = ref_width(psize);
        mis        = ref_mis(paddr, psize);
        wide_store = pwe && w == 4;
        lat        = mis ? 1 : (pwe && w < 4) ? 3 : 2;
        rd_age     = (mis || wide_store) ? -1 : 1;
        wr_age     = (mis || !pwe) ? -1 : (wide_store ? 1 : 2);
        idx        = int'(paddr[5:2]);
        check_eq("mem_read", mem_read, age == rd_age);
        check_eq("mem_write", mem_write, age == wr_age);
        if (age == rd_age || age == wr_age)
          check_eq("mem_addr", mem_addr, {paddr[31:2], 2'b00});
        if (age == wr_age)
          check_eq("mem_wdata", mem_wdata, ref_merge(ref_mem[idx], pwdata, paddr, psize));
        if (p0_rvalid | p1_rvalid) begin
          check_eq("rvalid_port", {p1_rvalid, p0_rvalid}, pport ? 2 : 1);
          check_eq("rvalid_latency", age, lat);
          check_eq("err", pport ? p1_err : p0_err, mis);
          if (!pwe)
            check_eq("rdata", pport ? p1_rdata : p0_rdata,
                     mis ? 32'd0 : ref_load(ref_mem[idx], paddr, psize));
          if (pwe && !mis) ref_mem[idx] = ref_merge(ref_mem[idx], pwdata, paddr, psize);
          pend = 1'b0;
          done = 1'b1;
        end else if (age >= lat) begin
          check_eq("rvalid_timeout", 0, 1);
          pend = 1'b0;
          done = 1'b1;
        end
      end else begin
        check_eq("idle_rvalid", {p1_rvalid, p0_rvalid}, 0);
        check_eq("idle_mem", {mem_read, mem_write}, 0);
        check_eq("idle_mem_addr", mem_addr, 0);
      end
      check_eq("gnt_onehot", p0_gnt & p1_gnt, 0);
      if (pend || done) begin
        check_eq("gnt_busy", p0_gnt | p1_gnt, 0);
      end else begin
        check_eq("gnt_present", p0_gnt | p1_gnt, p0_req | p1_req);
        if (p0_gnt | p1_gnt) begin
          if (p0_req && p1_req) check_eq("rr_winner", p1_gnt, !last_win);
          else                  check_eq("gnt_sole", p1_gnt, p1_req);
          last_win = p1_gnt;
          pport    = p1_gnt;
          pwe      = p1_gnt ? p1_we : p0_we;
          psize    = p1_gnt ? p1_size : p0_size;
          paddr    = p1_gnt ? p1_addr : p0_addr;
          pwdata   = p1_gnt ? p1_wdata : p0_wdata;
          pend     = 1'b1;
          age      = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_port(input bit port, input bit req, input bit we, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      p1_req = req; p1_we = we; p1_size = size; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = req; p0_we = we; p0_size = size; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  task automatic wait_gnt(input bit port);
    int n;
    n = 0;
    @(negedge clk);
    while (!(port ? p1_gnt : p0_gnt) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check_eq("gnt_timeout", 0, 1);
  endtask

  task automatic run_txn(input bit port, input bit we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int lat, output bit err);
    set_port(port, 1'b1, we, size, addr, wdata);
    wait_gnt(port);
    @(posedge clk); #1;
    set_port(port, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    lat = 0; rdata = 32'd0; err = 1'b0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (port ? p1_rvalid : p0_rvalid) begin
        rdata = port ? p1_rdata : p0_rdata;
        err   = port ? p1_err : p0_err;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [2:0] pick_size();
    case ($urandom_range(0, 4))
      0:       return SZ_B;
      1:       return SZ_H;
      2:       return SZ_W;
      3:       return SZ_BU;
      default: return SZ_HU;
    endcase
  endfunction

  task automatic drive_port(input bit port, input int n);
    int gap;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      set_port(port, 1'b1, 1'($urandom_range(0, 1)), pick_size(),
               32'h8000_0000 + $urandom_range(0, 63), $urandom);
      wait_gnt(port);
      @(posedge clk); #1;
      set_port(port, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    int          lat;
    bit          err;
    bit          gq[$];

    rst = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_port(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_rvalid", {p1_rvalid, p0_rvalid}, 0);
    check_eq("reset_rdata", p0_rdata | p1_rdata, 0);
    check_eq("reset_mem", {mem_read, mem_write}, 0);
    check_eq("reset_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_txn(1'b0, 1'b0, SZ_W, 32'h8000_0008, 32'd0, rd, lat, err);
    check_eq("lw_lat", lat, 2);
    check_eq("lw_data", rd, 32'h0000_0088);
    check_eq("lw_err", err, 0);

    run_txn(1'b0, 1'b0, SZ_B, 32'h8000_0011, 32'd0, rd, lat, err);
    check_eq("lb_data", rd, 32'hFFFF_FFF5);
    run_txn(1'b0, 1'b0, SZ_BU, 32'h8000_0011, 32'd0, rd, lat, err);
    check_eq("lbu_data", rd, 32'h0000_00F5);
    run_txn(1'b0, 1'b0, SZ_HU, 32'h8000_0012, 32'd0, rd, lat, err);
    check_eq("lhu_data", rd, 32'h0000_1234);
    run_txn(1'b1, 1'b0, SZ_H, 32'h8000_0010, 32'd0, rd, lat, err);
    check_eq("p1_lh_data", rd, 32'hFFFF_F5AA);
    check_eq("p1_lh_lat", lat, 2);

    run_txn(1'b0, 1'b1, SZ_B, 32'h8000_0022, 32'h0000_00CC, rd, lat, err);
    check_eq("sb_lat", lat, 3);
    check_eq("sb_mem", dmem[8], 32'h11CC_3344);

    run_txn(1'b1, 1'b1, SZ_W, 32'h8000_0030, 32'hCAFE_F00D, rd, lat, err);
    check_eq("sw_lat", lat, 2);
    check_eq("sw_mem", dmem[12], 32'hCAFE_F00D);

    run_txn(1'b0, 1'b0, SZ_W, 32'h8000_0002, 32'd0, rd, lat, err);
`ifdef DMEM_ARB_MISALIGN_EN
    check_eq("mis_lat", lat, 1);
    check_eq("mis_err", err, 1);
    check_eq("mis_data", rd, 0);
`else
    check_eq("unal_lat", lat, 2);
    check_eq("unal_err", err, 0);
    check_eq("unal_data", rd, init_word(0));
`endif

    // Reset during the WRITE cycle of a byte store.
    set_port(1'b0, 1'b1, 1'b1, SZ_B, 32'h8000_0024, 32'h0000_0055);
    wait_gnt(1'b0);
    @(posedge clk); #1;
    set_port(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstw_mem_write", mem_write, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstw_busy", busy, 0);
    check_eq("rstw_rvalid", {p1_rvalid, p0_rvalid}, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rstw_mem_kept", dmem[9], init_word(9));

    // Both ports request continuously from reset.
    rst = 1'b1;
    set_port(1'b0, 1'b1, 1'b0, SZ_W, 32'h8000_0000, 32'd0);
    set_port(1'b1, 1'b1, 1'b0, SZ_W, 32'h8000_0004, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (p0_gnt) gq.push_back(1'b0);
      if (p1_gnt) gq.push_back(1'b1);
    end
    @(posedge clk); #1;
    set_port(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_port(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("alt_count", gq.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      if (i < gq.size()) check_eq($sformatf("alt_gnt%0d", i), gq[i], i % 2);

    // Random concurrent traffic from both ports.
    fork
      drive_port(1'b0, 60);
      drive_port(1'b1, 60);
    join
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) check_eq($sformatf("final_mem%0d", i), dmem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sits between two data-memory requesters (port 0: core load/store unit; port 1: loader/debug master) and the single-port, word-wide data memory. It grants one requester at a time with round-robin arbitration and sequences each access over one to three cycles. Memory-side accesses are always full-word, so sub-word stores are done as read-modify-write and sub-word loads are lane-extracted and sign- or zero-extended here.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `pN_req`  in  1  request; held high until `pN_gnt` (N = 0, 1)
- `pN_we`  in  1  1 = store, 0 = load
- `pN_size`  in  3  RISC-V funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU; BU/HU are valid for loads only
- `pN_addr`  in  ADDR_W  byte address
- `pN_wdata`  in  32  store data, right-aligned
- `pN_gnt`  out  1  one-cycle pulse; request fields are sampled in this cycle
- `pN_rvalid`  out  1  one-cycle completion pulse (loads and stores)
- `pN_rdata`  out  32  load result; valid only when `pN_rvalid`=1, otherwise 0
- `pN_err`  out  1  misaligned-access flag, qualified by `pN_rvalid`
- `mem_read`  out  1  memory read enable; memory returns `mem_rdata` combinationally
- `mem_write`  out  1  memory write enable; memory writes on the next rising edge
- `mem_addr`  out  32  word-aligned byte address: {addr[31:2], 2'b00}
- `mem_wdata`  out  32  full-word write data
- `mem_data_type`  out  3  constant 3'b010 (word)
- `mem_rdata`  in  32  memory read data
- `busy`  out  1  high in any state other than IDLE

## Operation
States and transitions:
- **IDLE**
  - With any `req` high: grant one port, latch `we`, `size`, `addr`, `wdata` and the port id.
  - Next state: SW goes to WRITE; load or SB/SH goes to READ.
- **READ**
  - Drives `mem_read`=1 and captures `mem_rdata` into the word buffer.
  - Next state: load goes to RESP; SB/SH goes to WRITE.
- **WRITE**
  - Drives `mem_write`=1.
  - `mem_wdata` is the full word for SW, or the buffered word with the addressed lane replaced for SB/SH.
  - Next state: RESP.
- **RESP**
  - Pulses `rvalid` to the owning port, with `rdata` = extracted lane.
  - Next state: IDLE.

Lane selection and extension:
- Byte lane is `addr[1:0]`; halfword lane is `addr[1]`.
- B and H are sign-extended; BU and HU are zero-extended.

Arbitration:
- If exactly one port requests, it is granted.
- If both request, the port not granted last wins.
- The last-grant pointer resets to 1, so port 0 wins the first tie.

Request rules:
- Requests are ignored outside IDLE. `gnt` is never asserted outside IDLE.
- A store with size BU/HU is treated as B/H.

Reset:
- All outputs reset to 0, state resets to IDLE, buffers reset to 0.
- `mem_read` and `mem_write` are gated by `!rst`: no memory write occurs in a reset cycle, even mid-sequence.
- An in-flight transaction is dropped without `rvalid`.

## Timing
Grant is in cycle 0. Cycle counts:
- Load: READ in cycle 1, `rvalid` in cycle 2.
- SW: WRITE in cycle 1, `rvalid` in cycle 2.
- SB/SH: READ in cycle 1, WRITE in cycle 2, `rvalid` in cycle 3.
- Next grant is possible in the cycle after RESP.
- Maximum throughput is one access per 3 cycles (loads/SW) or per 4 cycles (SB/SH).

Output behaviour:
- `gnt` is combinational from IDLE and `req`.
- `rvalid` and `rdata` are registered.
- Memory-side outputs decode from state; `mem_addr` is 0 in IDLE.

## Configuration
Macro `DMEM_ARB_MISALIGN_EN`.
- **Defined:**
  - A request is misaligned if it is H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
  - A misaligned request goes IDLE to RESP directly, with no memory access; `rvalid` has `err`=1 and `rdata`=0.
- **Undefined:**
  - H ignores `addr[0]`; W ignores `addr[1:0]`.
  - `pN_err` is tied to 0.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum `{IDLE, READ, WRITE, RESP}`;
  - size constants `SZ_B`, `SZ_H`, `SZ_W`, `SZ_BU`, `SZ_HU`;
  - `MEM_TYPE_WORD` = 3'b010.
- Sub-module `dmem_lane_unit` is combinational:
  - load extract/extend: word, offset, size → rdata;
  - store merge: word, wdata, offset, size → merged word.

## Test plan
- Load W, port 0, addr 0x80000008, memory word 0x00000088 → `rvalid` in cycle 2, `rdata`=0x00000088, one `mem_read` cycle.
- Load B, addr 0x80000011, word 0x1234F5AA → `rdata`=0xFFFFFFF5. Load BU, same address → `rdata`=0x000000F5. Load HU, addr 0x80000012 → `rdata`=0x00001234.
- Store SB, wdata 0xCC, addr 0x80000022, word 0x11223344 → WRITE in cycle 2 with `mem_wdata`=0x11CC3344, `rvalid` in cycle 3.
- Both ports request continuously from reset → grants alternate 0, 1, 0, 1, with no `gnt` while busy.
- `rst` asserted during the WRITE state of an SB → `mem_write` stays 0 that cycle, no `rvalid`, state is IDLE the next cycle.
- With the macro defined, load W at 0x80000002 → `rvalid` in cycle 1, `err`=1, `rdata`=0, `mem_read` never asserted. Without the macro → normal word read of 0x80000000, `err`=0.
